// File: rtl/minimal_sopc_pkg.sv
// Shared definitions for the minimal SOPC: opcode/funct constants, ALU enums,
// inter-stage bundles and the operand-forwarding helper.
package minimal_sopc_pkg;

    localparam int unsigned REG_W   = 32;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_SYNC = 6'h0F;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_NOP, SEL_LOGIC, SEL_SHIFT
    } alu_sel_e;

    typedef struct packed {
        alu_op_e            op;
        alu_sel_e           sel;
        logic [REG_W-1:0]   op1;
        logic [REG_W-1:0]   op2;
        logic               wreg;
        logic [REG_AW-1:0]  wd;
    } id_ex_t;

    typedef struct packed {
        logic               wreg;
        logic [REG_AW-1:0]  wd;
        logic [REG_W-1:0]   wdata;
    } wb_t;

    // Youngest producer wins: EX result, then MEM result, then regfile.
    function automatic logic [REG_W-1:0] fwd_operand(
        input logic [REG_AW-1:0] a,
        input wb_t               ex,
        input wb_t               mem,
        input logic [REG_W-1:0]  rf
    );
        if (ex.wreg && ex.wd == a) return ex.wdata;
        if (mem.wreg && mem.wd == a) return mem.wdata;
        return rf;
    endfunction

endpackage

// File: rtl/minimal_sopc_if.sv
// Instruction fetch bus between core (master) and ROM (slave).
// ce: fetch enable, addr: ROM word address, inst: fetched word.
interface minimal_sopc_if #(
    parameter int unsigned AW = 10
) ();
    logic          ce;
    logic [AW-1:0] addr;
    logic [31:0]   inst;

    modport master (output ce, output addr, input inst);
    modport slave  (input ce, input addr, output inst);
endinterface

// File: rtl/minimal_sopc_core.sv
// 5-stage MIPS32 integer core (logic/shift subset) with full forwarding.
// Ports: clk, rst (async active-low), rom (fetch bus master).
module minimal_sopc_core
    import minimal_sopc_pkg::*;
#(
    parameter int unsigned ROM_AW   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    minimal_sopc_if.master rom
);
    logic [31:0]      pc_q, pc_d;
    logic             ce_q, ce_d;
    logic [31:0]      if_id_q, if_id_d;
    id_ex_t           id_ex_q, id_ex_d;
    wb_t              ex_mem_q, ex_mem_d;
    wb_t              mem_wb_q, mem_wb_d;
    wb_t              ex_wb;

    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [REG_W-1:0]  rdata1, rdata2, rs_val, rt_val;
    logic [REG_W-1:0]  logic_res, shift_res, ex_result;

    // IF
    assign rom.ce   = ce_q;
    assign rom.addr = pc_q[ROM_AW+1:2];

    always_comb begin
        ce_d    = 1'b1;
        pc_d    = ce_q ? pc_q + 32'd4 : RESET_PC;
        if_id_d = rom.inst;
    end

    // ID
    assign opcode = if_id_q[31:26];
    assign rs     = if_id_q[25:21];
    assign rt     = if_id_q[20:16];
    assign rd     = if_id_q[15:11];
    assign shamt  = if_id_q[10:6];
    assign funct  = if_id_q[5:0];
    assign imm    = if_id_q[15:0];

    regfile register (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (mem_wb_q.wreg),
        .waddr  (mem_wb_q.wd),
        .wdata  (mem_wb_q.wdata)
    );

    always_comb begin
        rs_val  = fwd_operand(rs, ex_wb, ex_mem_q, rdata1);
        rt_val  = fwd_operand(rt, ex_wb, ex_mem_q, rdata2);
        id_ex_d = '0;
        unique case (opcode)
            OP_SPECIAL: begin
                id_ex_d.wd   = rd;
                id_ex_d.wreg = 1'b1;
                id_ex_d.op1  = rs_val;
                id_ex_d.op2  = rt_val;
                unique case (funct)
                    F_AND:  id_ex_d.op = ALU_AND;
                    F_OR:   id_ex_d.op = ALU_OR;
                    F_XOR:  id_ex_d.op = ALU_XOR;
                    F_NOR:  id_ex_d.op = ALU_NOR;
                    F_SLLV: id_ex_d.op = ALU_SLL;
                    F_SRLV: id_ex_d.op = ALU_SRL;
                    F_SRAV: id_ex_d.op = ALU_SRA;
                    F_SLL: begin
                        id_ex_d.op  = ALU_SLL;
                        id_ex_d.op1 = {27'd0, shamt};
                    end
                    F_SRL: begin
                        id_ex_d.op  = ALU_SRL;
                        id_ex_d.op1 = {27'd0, shamt};
                    end
                    F_SRA: begin
                        id_ex_d.op  = ALU_SRA;
                        id_ex_d.op1 = {27'd0, shamt};
                    end
                    F_SYNC:  id_ex_d.op = ALU_NOP;
                    default: id_ex_d.op = ALU_NOP;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                id_ex_d.wd   = rt;
                id_ex_d.wreg = 1'b1;
                id_ex_d.op1  = rs_val;
                id_ex_d.op2  = {16'd0, imm};
                id_ex_d.op   = (opcode == OP_ANDI) ? ALU_AND :
                               (opcode == OP_ORI)  ? ALU_OR : ALU_XOR;
            end
            OP_LUI: begin
                id_ex_d.wd   = rt;
                id_ex_d.wreg = 1'b1;
                id_ex_d.op2  = {imm, 16'd0};
                id_ex_d.op   = ALU_OR;
            end
            default: id_ex_d.op = ALU_NOP;
        endcase
        unique case (id_ex_d.op)
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: id_ex_d.sel = SEL_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA:         id_ex_d.sel = SEL_SHIFT;
            default:                           id_ex_d.sel = SEL_NOP;
        endcase
        // Never carry a $0 write down the pipe, so forwarding cannot leak it.
        if (id_ex_d.op == ALU_NOP || id_ex_d.wd == '0) id_ex_d.wreg = 1'b0;
    end

    // EX
    always_comb begin
        logic_res = '0;
        shift_res = '0;
        unique case (id_ex_q.op)
            ALU_AND: logic_res = id_ex_q.op1 & id_ex_q.op2;
            ALU_OR:  logic_res = id_ex_q.op1 | id_ex_q.op2;
            ALU_XOR: logic_res = id_ex_q.op1 ^ id_ex_q.op2;
            ALU_NOR: logic_res = ~(id_ex_q.op1 | id_ex_q.op2);
            ALU_SLL: shift_res = id_ex_q.op2 << id_ex_q.op1[4:0];
            ALU_SRL: shift_res = id_ex_q.op2 >> id_ex_q.op1[4:0];
            ALU_SRA: shift_res = $signed(id_ex_q.op2) >>> id_ex_q.op1[4:0];
            default: ;
        endcase
        unique case (id_ex_q.sel)
            SEL_LOGIC: ex_result = logic_res;
            SEL_SHIFT: ex_result = shift_res;
            default:   ex_result = '0;
        endcase
        ex_wb.wreg  = id_ex_q.wreg;
        ex_wb.wd    = id_ex_q.wd;
        ex_wb.wdata = ex_result;
        ex_mem_d    = ex_wb;
        mem_wb_d    = ex_mem_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            ce_q     <= 1'b0;
            if_id_q  <= NOP_INST;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ce_q     <= ce_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end
endmodule

// File: rtl/minimal_sopc_inst_rom.sv
// Word-organised instruction ROM with combinational read.
// Ports: bus (slave) -- returns NOP while fetch is disabled.
module inst_rom
    import minimal_sopc_pkg::*;
#(
    parameter int unsigned ROM_WORDS = 1024,
    parameter int unsigned ROM_AW    = 10
) (
    minimal_sopc_if.slave bus
);
    // Image is loaded from outside by the simulation top.
    logic [31:0] inst_mem [0:ROM_WORDS-1];

    assign bus.inst = bus.ce ? inst_mem[bus.addr] : NOP_INST;
endmodule

// File: rtl/minimal_sopc_regfile.sv
// 32x32 register file: two async read ports with write-through, one sync write.
// Ports: clk, rst (async active-low), raddr1/2, rdata1/2, we, waddr, wdata.
module regfile
    import minimal_sopc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [REG_W-1:0]  rdata1,
    output logic [REG_W-1:0]  rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_W-1:0]  wdata
);
    logic [REG_W-1:0] storage [0:REG_NUM-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) storage[i] <= '0;
        end else if (we && waddr != '0) begin
            storage[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = storage[raddr1];
        if (raddr1 == '0) rdata1 = '0;
        else if (we && raddr1 == waddr) rdata1 = wdata;
    end

    always_comb begin
        rdata2 = storage[raddr2];
        if (raddr2 == '0) rdata2 = '0;
        else if (we && raddr2 == waddr) rdata2 = wdata;
    end
endmodule

// File: rtl/minimal_sopc.sv
// Minimal SOPC top: MIPS32 subset core plus instruction ROM.
// Ports: clk, rst (async active-low). Results live in cpu.register.storage.
module minimal_sopc #(
    parameter int unsigned ROM_WORDS = 1024,
    parameter int unsigned ROM_AW    = 10,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    minimal_sopc_if #(.AW(ROM_AW)) rom_bus ();

    inst_rom #(
        .ROM_WORDS (ROM_WORDS),
        .ROM_AW    (ROM_AW)
    ) inst_rom0 (
        .bus (rom_bus.slave)
    );

    minimal_sopc_core #(
        .ROM_AW   (ROM_AW),
        .RESET_PC (RESET_PC)
    ) cpu (
        .clk (clk),
        .rst (rst),
        .rom (rom_bus.master)
    );
endmodule

// File: tb/tb_minimal_sopc.sv
// Directed bench for minimal_sopc: program in ROM, results checked in the
// register file at the edge each instruction retires.
module tb_minimal_sopc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   edge_n = 0;

    minimal_sopc dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    logic [31:0] prog [0:25] = '{
        32'h3C020404, 32'h34420404, 32'h34070007, 32'h34050005,
        32'h34080008, 32'h00021200, 32'h00E21004, 32'h00021202,
        32'h00A21006, 32'h00000000, 32'h00000040, 32'h0000000F,
        32'h000214C0, 32'h00021403, 32'h01021007, 32'h34030055,
        32'h34000005, 32'h00001825, 32'h00452026, 32'h00803027,
        32'h00C74824, 32'h308AF0F0, 32'h394BFFFF, 32'h8C0C0004,
        32'h000B6802, 32'h00027007
    };

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic to_edge(input int n);
        while (edge_n < n) tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
        for (int i = 0; i < 26; i++) dut.inst_rom0.inst_mem[i] = prog[i];
        dut.inst_rom0.inst_mem[1023] = 32'h340F1234;

        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++)
            chk($sformatf("rst_r%0d", i), dut.cpu.register.storage[i], 32'h0);
        chk("rst_pc", dut.cpu.pc_q, 32'h0);
        chk("rst_ce", {31'd0, dut.cpu.ce_q}, 32'h0);
        chk("rst_we", {31'd0, dut.cpu.mem_wb_q.wreg}, 32'h0);

        @(negedge clk) rst = 1'b1;
        to_edge(1);
        chk("e1_ce", {31'd0, dut.cpu.ce_q}, 32'h1);
        chk("e1_pc", dut.cpu.pc_q, 32'h0);
        to_edge(2);
        chk("e2_pc", dut.cpu.pc_q, 32'h4);
        chk("e2_ifid", dut.cpu.if_id_q, 32'h3C020404);
        to_edge(5);
        chk("e5_r2", dut.cpu.register.storage[2], 32'h0);
        to_edge(6);
        chk("lui", dut.cpu.register.storage[2], 32'h04040000);
        to_edge(7);
        chk("ori_fwd", dut.cpu.register.storage[2], 32'h04040404);
        to_edge(8);
        chk("ori_r7", dut.cpu.register.storage[7], 32'h7);
        to_edge(9);
        chk("ori_r5", dut.cpu.register.storage[5], 32'h5);
        to_edge(10);
        chk("ori_r8", dut.cpu.register.storage[8], 32'h8);
        to_edge(11);
        chk("sll", dut.cpu.register.storage[2], 32'h04040400);
        to_edge(12);
        chk("sllv", dut.cpu.register.storage[2], 32'h02020000);
        to_edge(13);
        chk("srl", dut.cpu.register.storage[2], 32'h00020200);
        to_edge(14);
        chk("srlv", dut.cpu.register.storage[2], 32'h00001010);
        for (int e = 15; e <= 17; e++) begin
            to_edge(e);
            chk($sformatf("nop%0d_r2", e), dut.cpu.register.storage[2], 32'h00001010);
        end
        chk("nop_r5", dut.cpu.register.storage[5], 32'h5);
        chk("nop_r7", dut.cpu.register.storage[7], 32'h7);
        chk("nop_r8", dut.cpu.register.storage[8], 32'h8);
        chk("nop_r0", dut.cpu.register.storage[0], 32'h0);
        to_edge(18);
        chk("sll19", dut.cpu.register.storage[2], 32'h80800000);
        to_edge(19);
        chk("sra16", dut.cpu.register.storage[2], 32'hffff8080);
        to_edge(20);
        chk("srav8", dut.cpu.register.storage[2], 32'hffffff80);
        to_edge(21);
        chk("ori_r3", dut.cpu.register.storage[3], 32'h55);
        to_edge(22);
        chk("wr_r0", dut.cpu.register.storage[0], 32'h0);
        to_edge(23);
        chk("or_r0_fwd", dut.cpu.register.storage[3], 32'h0);
        to_edge(24);
        chk("xor", dut.cpu.register.storage[4], 32'hffffff85);
        to_edge(25);
        chk("nor", dut.cpu.register.storage[6], 32'h0000007a);
        to_edge(26);
        chk("and", dut.cpu.register.storage[9], 32'h2);
        to_edge(27);
        chk("andi", dut.cpu.register.storage[10], 32'h0000f080);
        to_edge(28);
        chk("xori", dut.cpu.register.storage[11], 32'h00000f7f);
        to_edge(29);
        chk("illegal", dut.cpu.register.storage[12], 32'h0);
        to_edge(30);
        chk("srl0", dut.cpu.register.storage[13], 32'h00000f7f);
        to_edge(31);
        chk("srav0", dut.cpu.register.storage[14], 32'hffffff80);

        to_edge(1028);
        chk("last_pre", dut.cpu.register.storage[15], 32'h0);
        to_edge(1029);
        chk("last_word", dut.cpu.register.storage[15], 32'h00001234);
        to_edge(1030);
        chk("wrap_lui", dut.cpu.register.storage[2], 32'h04040000);

        #2 rst = 1'b0;
        #1;
        chk("mid_r2", dut.cpu.register.storage[2], 32'h0);
        chk("mid_r15", dut.cpu.register.storage[15], 32'h0);
        chk("mid_pc", dut.cpu.pc_q, 32'h0);
        chk("mid_ce", {31'd0, dut.cpu.ce_q}, 32'h0);
        chk("mid_ifid", dut.cpu.if_id_q, 32'h0);
        chk("mid_we", {31'd0, dut.cpu.ex_mem_q.wreg}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_ce", {31'd0, dut.cpu.ce_q}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
